// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, legal byte-lane
// masks and the latency ceiling.
package CPU_Pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_MAX = 15;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  function automatic logic mask_legal(input logic [3:0] m);
    logic ok;
    case (m)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3, MASK_H0, MASK_H1, MASK_W: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port word array with per-byte write enables, synchronous write and
// combinational read.
module DMEM_Ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with LL/SC reservation tracking; stalls
// the memory stage until the single outstanding request completes.
module dmem_responder
  import CPU_Pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_atomic,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_scSuccess
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        res_valid;
  logic [AW-1:0] res_addr;

  logic        rd_p0, wr_p0, at_p0;
  logic [31:0] addr_p0, wdata_p0;
  logic [3:0]  mask_p0;

  logic        acc_rd, acc_wr, acc_at;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_mask;
  logic [AW-1:0] acc_idx;
  logic        capture, access, acc_err, sc_ok, ram_we;
  logic [31:0] ram_rdata;

  assign stall   = req_valid && (req_read || req_write) && (state != RESP);
  assign capture = (state == IDLE) && req_valid && (req_read || req_write);
  assign access  = (LATENCY == 1) ? capture : ((state == WAIT) && (cnt == WAIT_LAST));

  // Request capture stage: held for the access edge, not reset (data only)
  always_ff @(posedge clk) begin
    if (capture) begin
      rd_p0    <= req_read;
      wr_p0    <= req_write;
      at_p0    <= req_atomic;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      mask_p0  <= req_mask;
    end
  end

  // With LATENCY=1 capture and access share one edge, so the live inputs are used
  always_comb begin
    acc_rd    = rd_p0;
    acc_wr    = wr_p0;
    acc_at    = at_p0;
    acc_addr  = addr_p0;
    acc_wdata = wdata_p0;
    acc_mask  = mask_p0;
    if (LATENCY == 1) begin
      acc_rd    = req_read;
      acc_wr    = req_write;
      acc_at    = req_atomic;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_mask  = req_mask;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign acc_err = (acc_rd && acc_wr) || !mask_legal(acc_mask) ||
                   (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);
  assign sc_ok   = res_valid && (res_addr == acc_idx);
  assign ram_we  = access && !rst && !acc_err && acc_wr && (!acc_at || sc_ok);

  DMEM_Ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (acc_mask),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // Control FSM and registered response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_error     <= 1'b0;
      rsp_scSuccess <= 1'b0;
      res_valid     <= 1'b0;
    end else begin
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_error     <= 1'b0;
      rsp_scSuccess <= 1'b0;
      case (state)
        IDLE: if (capture) begin
          cnt   <= 4'd0;
          state <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: if (cnt == WAIT_LAST) state <= RESP;
              else cnt <= cnt + 4'd1;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (access) begin
        rsp_valid <= 1'b1;
        if (acc_err) begin
          rsp_error <= 1'b1;
        end else if (acc_rd) begin
          rsp_rdata <= ram_rdata;
          if (acc_at) begin
            res_valid <= 1'b1;
            res_addr  <= acc_idx;
          end
        end else if (acc_at) begin
          res_valid     <= 1'b0;
          rsp_rdata     <= {31'd0, sc_ok};
          rsp_scSuccess <= sc_ok;
        end else if (sc_ok) begin
          // Plain store to the reserved word breaks the reservation
          res_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words of internal storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request capture to response (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, a request present from the memory stage.
REQ-006 SHALL have ports req_read and req_write, input, 1 each, the load and store strobes.
REQ-007 SHALL have port req_atomic, input, 1: a read with it set is LL, and a write with it set is SC.
REQ-008 SHALL have port req_addr, input, 32, the byte address.
REQ-009 SHALL have port req_wdata, input, 32, the store data, already lane-aligned.
REQ-010 SHALL have port req_mask, input, 4, the byte-lane enables, bit i for byte i.
REQ-011 SHALL have port stall, output, 1, which holds the pipeline while a request is outstanding.
REQ-012 SHALL have port rsp_valid, output, 1, a one-cycle response strobe.
REQ-013 SHALL have port rsp_rdata, output, 32, the read word, or the SC result (1 or 0).
REQ-014 SHALL have port rsp_error, output, 1, which flags an illegal request.
REQ-015 SHALL have port rsp_scSuccess, output, 1, which is high when an SC committed.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-017 SHALL combinationally drive stall = req_valid && (req_read || req_write) && state != RESP.
REQ-018 SHALL, in IDLE with a valid read or write, capture the request and go to WAIT, or go directly to RESP when LATENCY=1.
REQ-019 SHALL count LATENCY-1 cycles in WAIT, so rsp_valid rises exactly LATENCY cycles after capture.
REQ-020 SHALL spend exactly one cycle in RESP, with rsp_valid=1 and stall=0, then return to IDLE; the pipeline advances on that edge.
REQ-021 SHALL perform the storage access (read or lane write) on the WAIT→RESP transition, or the IDLE→RESP transition when LATENCY=1, using only the captured request.
REQ-022 SHALL leave the requester responsible for holding request inputs stable while stall=1; the block ignores input changes after capture.
REQ-023 SHALL treat these as illegal, setting rsp_error=1 with no storage write, no reservation change, rsp_rdata=0 and rsp_scSuccess=0:
- req_read and req_write both set;
- req_mask not in {0001,0010,0100,1000,0011,1100,1111};
- req_addr[1:0] != 0;
- req_addr >= DEPTH*4.
REQ-024 SHALL, on a legal write, update only the bytes whose mask bit is set, taking them from the same lanes of req_wdata.
REQ-025 SHALL, on a legal read, return the full word; lane extraction and sign extension are done by the requester.
REQ-026 SHALL, on LL, read as normal and also set resValid=1 and resAddr to the word index.
REQ-027 SHALL commit an SC only when resValid is set and resAddr matches. On commit, write per the mask, set rsp_scSuccess=1 and set rsp_rdata=1. Otherwise, write nothing and set rsp_rdata=0.
REQ-028 SHALL clear resValid on every SC, whether or not it succeeds.
REQ-029 SHALL clear resValid on any non-atomic write to resAddr.
REQ-030 SHALL hold rsp_rdata, rsp_error and rsp_scSuccess at 0 whenever rsp_valid=0.
REQ-031 SHALL drive a request with req_valid=1 and neither strobe as a no-op: stall=0 and no response.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set state=IDLE, the counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_scSuccess=0 and resValid=0.
REQ-033 SHALL discard any request in flight at reset without performing its write.
REQ-034 SHALL not clear storage contents on reset.
REQ-035 SHALL let stall follow REQ-017 during reset.

Structure
REQ-036 SHALL place the state enum, the legal-mask constants and LATENCY_MAX=15 in the shared package CPU_Pkg.
REQ-037 SHALL instantiate storage as a sub-module DMEM_Ram: a single-port, byte-write-enable array of DEPTH×32 with synchronous write and combinational read.

Verification
REQ-038 SHALL cover: write 0x0000_0010, data 0xDEADBEEF, mask 1111, LATENCY=2; then a read of the same address -> each stall high 2 cycles, rsp_valid on the 3rd, rsp_rdata=0xDEADBEEF.
REQ-039 SHALL cover: from 0xDEADBEEF, write 0x0000_AA00 with mask 0010 -> a read returns 0xDEADAAEF.
REQ-040 SHALL cover: LL 0x20, then SC 0x20 with 0x5, then SC 0x20 again -> the first gives scSuccess=1 and rdata=1 with the word = 5; the second gives rdata=0 and the word is unchanged.
REQ-041 SHALL cover: LL 0x20, then a plain write to 0x20, then SC 0x20 -> the SC fails, rdata=0.
REQ-042 SHALL cover: read 0x2 (misaligned), and a write with mask 0101 -> rsp_error=1, rdata=0, storage unchanged.
REQ-043 SHALL cover: rst asserted in the WAIT of a write to 0x40 -> the next cycle is IDLE with rsp_valid=0, and the word at 0x40 is unchanged.
